// File: rtl/rcs_pkg.sv
// ============================================================================
// Module      : rcs_pkg
// Description : Shared types and constants for the serial ripple-borrow
//               subtractor.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package rcs_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_SLICE = 8;
    localparam int MAX_WIDTH = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Callers truncate the result to their own WIDTH.
    function automatic logic [MAX_WIDTH-1:0] sat_pos(input int width);
        return (MAX_WIDTH'(1) << (width - 1)) - MAX_WIDTH'(1);
    endfunction

    function automatic logic [MAX_WIDTH-1:0] sat_neg(input int width);
        return MAX_WIDTH'(1) << (width - 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/rcs_serial_sub_if.sv
// ============================================================================
// Module      : rcs_serial_sub_if
// Description : Operand/result valid-ready bundle of the serial subtractor.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface rcs_serial_sub_if
    import rcs_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, ovf, zero
    );
endinterface

`default_nettype wire

// File: rtl/rcs_serial_sub_slice.sv
// ============================================================================
// Module      : sub_slice
// Description : Combinational SLICE-bit subtractor with borrow in/out.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module sub_slice #(
    parameter int SLICE = 8
) (
    input  wire logic [SLICE-1:0] i_a,
    input  wire logic [SLICE-1:0] i_b,
    input  wire logic             i_bin,
    output logic      [SLICE-1:0] o_d,
    output logic                  o_bout
);
    logic [SLICE:0] w_full;

    // One extra bit catches the borrow: it is set iff a < b + bin.
    assign w_full = {1'b0, i_a} - {1'b0, i_b} - {{SLICE{1'b0}}, i_bin};
    assign o_d    = w_full[SLICE-1:0];
    assign o_bout = w_full[SLICE];
endmodule

`default_nettype wire

// File: rtl/rcs_serial_sub.sv
// ============================================================================
// Module      : rcs_serial_sub
// Description : Serial a - b - bin, one SLICE-bit slice per clock, LSB first.
//               Define RCS_SAT_EN for signed saturation of diff on overflow.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module rcs_serial_sub
    import rcs_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SLICE = DEF_SLICE
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    rcs_serial_sub_if.slave bus
);
    localparam int             c_NSLICE = WIDTH / SLICE;
    localparam int             c_IDXW   = (c_NSLICE > 1) ? $clog2(c_NSLICE) : 1;
    localparam logic [c_IDXW-1:0] c_LAST = c_IDXW'(c_NSLICE - 1);

    state_t             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_diff;
    logic               r_borrow;
    logic [c_IDXW-1:0]  r_idx;
    logic               r_in_ready;
    logic               r_out_valid;
    logic               r_bout;
    logic               r_ovf;
    logic               r_zero;

    logic [SLICE-1:0]   w_a_sl;
    logic [SLICE-1:0]   w_b_sl;
    logic [SLICE-1:0]   w_d;
    logic               w_bo;
    logic [WIDTH-1:0]   w_raw;
    logic [WIDTH-1:0]   w_res;
    logic               w_ovf;

    assign w_a_sl = r_a[r_idx*SLICE +: SLICE];
    assign w_b_sl = r_b[r_idx*SLICE +: SLICE];

    sub_slice #(.SLICE(SLICE)) u_slice (
        .i_a    (w_a_sl),
        .i_b    (w_b_sl),
        .i_bin  (r_borrow),
        .o_d    (w_d),
        .o_bout (w_bo)
    );

`ifdef RCS_SAT_EN
    localparam logic [WIDTH-1:0] c_SAT_POS = WIDTH'(sat_pos(WIDTH));
    localparam logic [WIDTH-1:0] c_SAT_NEG = WIDTH'(sat_neg(WIDTH));
`endif

    // Final result as it stands while the top slice is being computed.
    always_comb begin
        w_raw = r_acc;
        w_raw[(c_NSLICE-1)*SLICE +: SLICE] = w_d;
        w_ovf = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_raw[WIDTH-1] != r_a[WIDTH-1]);
`ifdef RCS_SAT_EN
        w_res = w_ovf ? (r_a[WIDTH-1] ? c_SAT_NEG : c_SAT_POS) : w_raw;
`else
        w_res = w_raw;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_acc       <= '0;
            r_diff      <= '0;
            r_borrow    <= 1'b0;
            r_idx       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_bout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_zero      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_a        <= bus.a;
                        r_b        <= bus.b;
                        r_borrow   <= bus.bin;
                        r_idx      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= CALC;
                    end
                end
                CALC: begin
                    r_acc[r_idx*SLICE +: SLICE] <= w_d;
                    r_borrow <= w_bo;
                    if (r_idx == c_LAST) begin
                        r_diff      <= w_res;
                        r_bout      <= w_bo;
                        r_ovf       <= w_ovf;
                        r_zero      <= (w_res == '0);
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.diff      = r_diff;
    assign bus.bout      = r_bout;
    assign bus.ovf       = r_ovf;
    assign bus.zero      = r_zero;
endmodule

`default_nettype wire

// File: tb/tb_rcs_serial_sub.sv
// ============================================================================
// Module      : tb_rcs_serial_sub
// Description : Self-checking bench for rcs_serial_sub (directed + random).
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rcs_serial_sub;
    import rcs_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    bit   started = 1'b0;

    always #5 clk = ~clk;

    rcs_serial_sub_if #(.WIDTH(32)) bus ();

    rcs_serial_sub #(.WIDTH(32), .SLICE(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // {zero, ovf, bout, diff} straight from the arithmetic definition.
    function automatic logic [34:0] ref_sub(input logic [31:0] x, input logic [31:0] y, input logic bi);
        logic [31:0] raw;
        logic [31:0] res;
        logic        bo;
        logic        ov;
        raw = x - y - {31'd0, bi};
        bo  = ({1'b0, x} < ({1'b0, y} + {32'd0, bi}));
        ov  = (x[31] != y[31]) && (raw[31] != x[31]);
        res = raw;
`ifdef RCS_SAT_EN
        if (ov) res = x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
        return {(res == 32'd0), ov, bo, res};
    endfunction

    // Transaction-level model: accept when ready, publish 4 cycles later, hold until taken.
    logic        m_ir = 1'b1;
    logic        m_ov = 1'b0;
    int          m_cnt = 0;
    logic [31:0] m_a = '0, m_b = '0;
    logic        m_bin = 1'b0;
    logic [34:0] m_res = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ir  <= 1'b1;
            m_ov  <= 1'b0;
            m_cnt <= 0;
            m_res <= '0;
        end else if (m_ov) begin
            if (bus.out_ready) begin
                m_ov <= 1'b0;
                m_ir <= 1'b1;
            end
        end else if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                m_res <= ref_sub(m_a, m_b, m_bin);
                m_ov  <= 1'b1;
            end
        end else if (bus.in_valid) begin
            m_a   <= bus.a;
            m_b   <= bus.b;
            m_bin <= bus.bin;
            m_ir  <= 1'b0;
            m_cnt <= 4;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("in_ready",  {31'd0, bus.in_ready},  {31'd0, m_ir});
            check("out_valid", {31'd0, bus.out_valid}, {31'd0, m_ov});
            check("diff",      bus.diff,               m_res[31:0]);
            check("bout",      {31'd0, bus.bout},      {31'd0, m_res[32]});
            check("ovf",       {31'd0, bus.ovf},       {31'd0, m_res[33]});
            check("zero",      {31'd0, bus.zero},      {31'd0, m_res[34]});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!bus.in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!bus.in_ready) check("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic bi);
        wait_ready();
        bus.a = x;
        bus.b = y;
        bus.bin = bi;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic do_op(input logic [31:0] x, input logic [31:0] y, input logic bi,
                         input logic [31:0] ed, input logic eb, input logic eo, input logic ez,
                         input int hold);
        int lat = 0;
        issue(x, y, bi);
        while (!bus.out_valid && lat < 20) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.a = $urandom;
            bus.b = $urandom;
            tick();
            lat++;
        end
        bus.in_valid = 1'b0;
        check("latency", lat, 32'd4);
        check("lit_diff", bus.diff, ed);
        check("lit_bout", {31'd0, bus.bout}, {31'd0, eb});
        check("lit_ovf",  {31'd0, bus.ovf},  {31'd0, eo});
        check("lit_zero", {31'd0, bus.zero}, {31'd0, ez});
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            tick();
            check("hold_diff", bus.diff, ed);
            check("hold_valid", {31'd0, bus.out_valid}, 32'd1);
            check("hold_inready", {31'd0, bus.in_ready}, 32'd0);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("post_valid", {31'd0, bus.out_valid}, 32'd0);
        check("post_inready", {31'd0, bus.in_ready}, 32'd1);
        check("post_diff_kept", bus.diff, ed);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.bin = 1'b0;
        rst_n = 1'b0;
        repeat (3) tick();
        started = 1'b1;
        check("rst_inready", {31'd0, bus.in_ready}, 32'd1);
        check("rst_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_diff", bus.diff, 32'd0);
        rst_n = 1'b1;
        tick();

        do_op(32'd5, 32'd3, 1'b0, 32'h0000_0002, 1'b0, 1'b0, 1'b0, 0);
        do_op(32'd0, 32'd1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 0);
        do_op(32'd7, 32'd6, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1);
        do_op(32'h0001_0000, 32'd1, 1'b0, 32'h0000_FFFF, 1'b0, 1'b0, 1'b0, 0);
`ifdef RCS_SAT_EN
        do_op(32'h8000_0000, 32'd1, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 0);
        do_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 0);
`else
        do_op(32'h8000_0000, 32'd1, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 0);
        do_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b1, 1'b0, 0);
`endif
        do_op(32'h1234_5678, 32'h1234_5678, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 3);
        do_op(32'hCAFE_F00D, 32'd0, 1'b0, 32'hCAFE_F00D, 1'b0, 1'b0, 1'b0, 2);

        // Reset while the second slice is in flight.
        issue(32'h0000_DEAD, 32'd1, 1'b0);
        tick();
        rst_n = 1'b0;
        #1;
        check("arst_valid", {31'd0, bus.out_valid}, 32'd0);
        check("arst_inready", {31'd0, bus.in_ready}, 32'd1);
        check("arst_diff", bus.diff, 32'd0);
        check("arst_flags", {29'd0, bus.bout, bus.ovf, bus.zero}, 32'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("no_ghost", {31'd0, bus.out_valid}, 32'd0);
        end
        do_op(32'd9, 32'd4, 1'b0, 32'd5, 1'b0, 1'b0, 1'b0, 0);

        // Random traffic checked cycle by cycle against the model.
        for (int i = 0; i < 500; i++) begin
            @(posedge clk);
            #1;
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.bin = 1'($urandom_range(0, 1));
            bus.a = $urandom;
            case ($urandom_range(0, 5))
                0: bus.b = bus.a;
                1: bus.b = 32'd0;
                2: begin bus.a = 32'h8000_0000; bus.b = $urandom_range(0, 3); end
                3: begin bus.a = 32'h7FFF_FFFF; bus.b = 32'hFFFF_FFFF - $urandom_range(0, 3); end
                default: bus.b = $urandom;
            endcase
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        repeat (10) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

`default_nettype wire
